// File: rtl/sa_skew_feeder_pkg.sv
// Shared types for the systolic-array skew feeder.
// Provides the Scalar lane type, array-size macros and the feeder FSM states.
`ifndef SYS_ARRAY_LEN
`define SYS_ARRAY_LEN 4
`endif
`ifndef SINGLE_WIDTH
`define SINGLE_WIDTH 32
`endif
`ifndef SINGLE
`define SINGLE logic [`SINGLE_WIDTH-1:0]
`endif

package sa_skew_feeder_pkg;

    localparam int ARRAY_LEN = `SYS_ARRAY_LEN;
    localparam int SW        = `SINGLE_WIDTH;

    typedef struct packed {
        logic [SW-1:0] data;
        logic          valid;
    } Scalar;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } feeder_state_t;

endpackage

// File: rtl/sa_skew_feeder_delay.sv
// skew_delay: fixed-length registered chain of Scalar stages.
// Ports: clk, rst_n (sync, active-low), d (Scalar in), q (Scalar out, DELAY cycles later).
module skew_delay
    import sa_skew_feeder_pkg::*;
#(
    parameter int DELAY = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  Scalar d,
    output Scalar q
);

    Scalar stage [DELAY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DELAY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DELAY-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: sequences one systolic tile (clear, feed, flush, drain, done)
// and re-times each accepted K-slice into the diagonal skew the array expects.
// Ports: clk, rst_n (sync, active-low), start/k_len (tile request), in_valid/in_ready
// with a_vec/b_vec (K-slice beat), row/column (skewed lanes to array), clear,
// array_ready (array empty), busy, done.
module sa_skew_feeder
    import sa_skew_feeder_pkg::*;
#(
    parameter int LEN = ARRAY_LEN,
    parameter int KW  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] a_vec [LEN],
    input  logic [SW-1:0] b_vec [LEN],
    output Scalar         row [LEN],
    output Scalar         column [LEN],
    output logic          clear,
    input  logic          array_ready,
    output logic          busy,
    output logic          done
);

    localparam int FW = $clog2(LEN + 1);

    feeder_state_t state, state_n;

    logic [KW-1:0] k_q;
    logic [KW-1:0] beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic          hs;
    logic          last_beat;
    logic          flush_end;

    assign hs        = in_valid & in_ready;
    assign last_beat = hs && ((beat_cnt + KW'(1)) == k_q);
    assign flush_end = (flush_cnt == FW'(LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q       <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                k_q <= k_len;
            end
            if (state == ST_CLEAR) begin
                beat_cnt <= '0;
            end else if (hs) begin
                beat_cnt <= beat_cnt + KW'(1);
            end
            if (state == ST_FLUSH) begin
                flush_cnt <= flush_cnt + FW'(1);
            end else begin
                flush_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        clear    = 1'b0;
        done     = 1'b0;
        busy     = 1'b1;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    // An empty tile skips the array entirely.
                    state_n = (k_len == '0) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear   = 1'b1;
                state_n = ST_FEED;
            end
            ST_FEED: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_n = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_end) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (array_ready) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Non-handshake cycles shift an all-zero bubble so both sides stay aligned.
    for (genvar i = 0; i < LEN; i++) begin : g_lane
        Scalar a_in;
        Scalar b_in;

        assign a_in.valid = hs;
        assign a_in.data  = hs ? a_vec[i] : '0;
        assign b_in.valid = hs;
        assign b_in.data  = hs ? b_vec[i] : '0;

        skew_delay #(.DELAY(i + 1)) u_row (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (a_in),
            .q     (row[i])
        );

        skew_delay #(.DELAY(i + 1)) u_col (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (b_in),
            .q     (column[i])
        );
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Self-checking bench for sa_skew_feeder: lane scoreboard, array/MAC model,
// and per-scenario timing checks.
module tb_sa_skew_feeder;
    import sa_skew_feeder_pkg::*;

    localparam int LEN = 4;
    localparam int KW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] a_vec [LEN];
    logic [SW-1:0] b_vec [LEN];
    Scalar         row [LEN];
    Scalar         column [LEN];
    logic          clear;
    logic          array_ready = 1'b1;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sa_skew_feeder #(.LEN(LEN), .KW(KW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .k_len       (k_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_vec       (a_vec),
        .b_vec       (b_vec),
        .row         (row),
        .column      (column),
        .clear       (clear),
        .array_ready (array_ready),
        .busy        (busy),
        .done        (done)
    );

    // ---------------- lane scoreboard ----------------
    typedef struct packed {
        int            cyc;
        logic [SW-1:0] a;
        logic [SW-1:0] b;
    } exp_t;

    exp_t sb [LEN][$];
    exp_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LEN; i++) sb[i].delete();
        end else begin
            for (int i = 0; i < LEN; i++) begin
                if (row[i].valid || column[i].valid) begin
                    n_tests++;
                    if (sb[i].size() == 0) begin
                        n_fail++;
                        $display("FAIL lane%0d_unexpected cyc=%0d row=%0d col=%0d want none",
                                 i, cyc, row[i].data, column[i].data);
                    end else begin
                        e = sb[i].pop_front();
                        if (!row[i].valid || !column[i].valid || row[i].data !== e.a ||
                            column[i].data !== e.b || cyc != e.cyc) begin
                            n_fail++;
                            $display("FAIL lane%0d_data got cyc=%0d v=%b%b a=%0d b=%0d want cyc=%0d a=%0d b=%0d",
                                     i, cyc, row[i].valid, column[i].valid, row[i].data,
                                     column[i].data, e.cyc, e.a, e.b);
                        end
                    end
                end else begin
                    if (sb[i].size() != 0 && sb[i][0].cyc <= cyc) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL lane%0d_missing got invalid at cyc=%0d want valid", i, cyc);
                        void'(sb[i].pop_front());
                    end
                    if (row[i].data !== '0 || column[i].data !== '0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL lane%0d_idle_data got row=%0d col=%0d want 0",
                                 i, row[i].data, column[i].data);
                    end
                end
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < LEN; i++) begin
                    sb[i].push_back('{cyc: cyc + 1 + i, a: a_vec[i], b: b_vec[i]});
                end
            end
        end
    end

    // ---------------- array + MAC model ----------------
    Scalar         pa [LEN][LEN];
    Scalar         pb [LEN][LEN];
    Scalar         a_l [LEN][LEN];
    Scalar         b_t [LEN][LEN];
    logic [SW-1:0] acc [LEN][LEN];

    always_comb begin
        for (int v = 0; v < LEN; v++) begin
            for (int h = 0; h < LEN; h++) begin
                a_l[v][h] = (h == 0) ? row[v] : pa[v][(h == 0) ? 0 : h - 1];
                b_t[v][h] = (v == 0) ? column[h] : pb[(v == 0) ? 0 : v - 1][h];
            end
        end
    end

    always @(negedge clk) begin
        for (int v = 0; v < LEN; v++) begin
            for (int h = 0; h < LEN; h++) begin
                if (!rst_n) begin
                    pa[v][h]  <= '0;
                    pb[v][h]  <= '0;
                    acc[v][h] <= '0;
                end else begin
                    pa[v][h] <= a_l[v][h];
                    pb[v][h] <= b_t[v][h];
                    if (clear) acc[v][h] <= '0;
                    else if (a_l[v][h].valid && b_t[v][h].valid)
                        acc[v][h] <= acc[v][h] + a_l[v][h].data * b_t[v][h].data;
                    if (a_l[v][h].valid || b_t[v][h].valid) begin
                        n_tests++;
                        if (a_l[v][h].valid !== b_t[v][h].valid) begin
                            n_fail++;
                            $display("FAIL pe%0d%0d_pairing got a_v=%b b_v=%b want equal",
                                     v, h, a_l[v][h].valid, b_t[v][h].valid);
                        end
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat;
        for (int i = 0; i < LEN; i++) begin
            a_vec[i] = SW'($urandom_range(0, 255));
            b_vec[i] = SW'($urandom_range(0, 255));
        end
    endtask

    task automatic wait_in_ready;
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_timeout got=%b want=1", in_ready);
        end
    endtask

    task automatic wait_done;
        int n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout got=%b want=1", done);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({clear, done, busy, in_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b want=0000", {clear, done, busy, in_ready});
        end
        for (int i = 0; i < LEN; i++) begin
            n_tests++;
            if (row[i] !== '0 || column[i] !== '0) begin
                n_fail++;
                $display("FAIL reset_lane%0d got row=%h col=%h want 0", i, row[i], column[i]);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_beat;
        logic [6:0] got, want;
        start = 1'b1;
        k_len = 8'd1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            start    = 1'b0;
            in_valid = 1'b0;
            got  = {clear, in_ready, done, row[0].valid, column[0].valid,
                    row[3].valid, column[3].valid};
            want = {e == 1, e == 2, e == 8, e == 3, e == 3, e == 6, e == 6};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL single_ctrl_e%0d got=%b want=%b", e, got, want);
            end
            if (e == 3) begin
                n_tests++;
                if (row[0].data !== SW'(1) || column[0].data !== SW'(5)) begin
                    n_fail++;
                    $display("FAIL single_lane0 got a=%0d b=%0d want a=1 b=5",
                             row[0].data, column[0].data);
                end
            end
            if (e == 6) begin
                n_tests++;
                if (row[3].data !== SW'(4) || column[3].data !== SW'(8)) begin
                    n_fail++;
                    $display("FAIL single_lane3 got a=%0d b=%0d want a=4 b=8",
                             row[3].data, column[3].data);
                end
            end
            if (e == 2) begin
                for (int i = 0; i < LEN; i++) begin
                    a_vec[i] = SW'(i + 1);
                    b_vec[i] = SW'(i + 5);
                end
                in_valid = 1'b1;
            end
        end
    endtask

    task automatic test_bubbles;
        int am [LEN][4];
        int bm [4][LEN];
        int sum;
        int k = 0;
        bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int kk = 0; kk < 4; kk++) begin
            for (int i = 0; i < LEN; i++) begin
                am[i][kk] = $urandom_range(1, 15);
                bm[kk][i] = $urandom_range(1, 15);
            end
        end
        start = 1'b1;
        k_len = 8'd4;
        tick();
        start = 1'b0;
        wait_in_ready();
        for (int c = 0; c < 6; c++) begin
            in_valid = pat[c];
            if (pat[c]) begin
                for (int i = 0; i < LEN; i++) begin
                    a_vec[i] = SW'(am[i][k]);
                    b_vec[i] = SW'(bm[k][i]);
                end
                k++;
            end
            tick();
        end
        in_valid = 1'b0;
        wait_done();
        for (int n = 0; n < 4; n++) tick();
        for (int v = 0; v < LEN; v++) begin
            for (int h = 0; h < LEN; h++) begin
                sum = 0;
                for (int kk = 0; kk < 4; kk++) sum += am[v][kk] * bm[kk][h];
                n_tests++;
                if (acc[v][h] !== SW'(sum)) begin
                    n_fail++;
                    $display("FAIL mac_c%0d%0d got=%0d want=%0d", v, h, acc[v][h], sum);
                end
            end
        end
    endtask

    task automatic test_k_zero;
        start = 1'b1;
        k_len = 8'd0;
        tick();
        start = 1'b0;
        n_tests++;
        if ({done, clear, busy, in_ready} !== 4'b1010) begin
            n_fail++;
            $display("FAIL kzero_done got=%b want=1010", {done, clear, busy, in_ready});
        end
        tick();
        n_tests++;
        if ({done, clear, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL kzero_idle got=%b want=000", {done, clear, busy});
        end
        for (int n = 0; n < 6; n++) tick();
    endtask

    task automatic test_drain_stall;
        int d = 2 + LEN + 2;
        start = 1'b1;
        k_len = 8'd2;
        array_ready = 1'b0;
        for (int e = 1; e <= d + 8; e++) begin
            tick();
            start = 1'b0;
            array_ready = (e >= d + 5);
            in_valid = (e == 2 || e == 3);
            if (in_valid) rand_beat();
            n_tests++;
            if ({busy, done} !== {e <= d + 6, e == d + 6}) begin
                n_fail++;
                $display("FAIL stall_e%0d got busy,done=%b want=%b%b",
                         e, {busy, done}, e <= d + 6, e == d + 6);
            end
        end
        in_valid = 1'b0;
        array_ready = 1'b1;
    endtask

    task automatic test_start_in_feed;
        start = 1'b1;
        k_len = 8'd3;
        tick();
        start = 1'b0;
        wait_in_ready();
        for (int b = 0; b < 3; b++) begin
            rand_beat();
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            if (b == 0) begin
                start = 1'b1;
                k_len = 8'd1;
                tick();
                start = 1'b0;
            end
            n_tests++;
            if (in_ready !== (b < 2)) begin
                n_fail++;
                $display("FAIL feed_count_b%0d got in_ready=%b want=%b", b, in_ready, b < 2);
            end
        end
        wait_done();
        tick();
        start = 1'b1;
        k_len = 8'd1;
        tick();
        start = 1'b0;
        n_tests++;
        if ({clear, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_clear got clear,busy=%b want=11", {clear, busy});
        end
        wait_in_ready();
        rand_beat();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done();
        tick();
    endtask

    task automatic test_reset_mid_feed;
        bit saw_done = 1'b0;
        start = 1'b1;
        k_len = 8'd8;
        tick();
        start = 1'b0;
        wait_in_ready();
        for (int b = 0; b < 3; b++) begin
            rand_beat();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++;
        if ({busy, in_ready, clear, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_ctrl got=%b want=0000", {busy, in_ready, clear, done});
        end
        for (int i = 0; i < LEN; i++) begin
            n_tests++;
            if (row[i] !== '0 || column[i] !== '0) begin
                n_fail++;
                $display("FAIL midrst_lane%0d got row=%h col=%h want 0", i, row[i], column[i]);
            end
        end
        for (int n = 0; n < 20; n++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        n_tests++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_done got=%b want=0", saw_done);
        end
    endtask

    task automatic test_sb_drained;
        int left = 0;
        for (int i = 0; i < LEN; i++) left += sb[i].size();
        n_tests++;
        if (left != 0) begin
            n_fail++;
            $display("FAIL sb_drained got=%0d pending want=0", left);
        end
    endtask

    initial begin
        for (int i = 0; i < LEN; i++) begin
            a_vec[i] = '0;
            b_vec[i] = '0;
        end
        test_reset();
        test_single_beat();
        test_bubbles();
        test_k_zero();
        test_drain_stall();
        test_start_in_feed();
        test_reset_mid_feed();
        test_sb_drained();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
